// File: rtl/m_gen_pkg.sv
// Shared widths, mode and state encodings for the M-generation sequencer.
package m_gen_pkg;

  localparam logic MODE_J_OUTER = 1'b0;
  localparam logic MODE_A_OUTER = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned aw_f(input int unsigned a);
    return $clog2(a) + 1;
  endfunction

  function automatic int unsigned jw_f(input int unsigned j);
    return $clog2(j) + 1;
  endfunction

  function automatic int unsigned cw_f(input int unsigned j, input int unsigned a);
    return $clog2(j * a + 1);
  endfunction

endpackage

// File: rtl/m_gen_seq_symbol_replace.sv
// Combinational single-symbol substitution: symbol j of vec replaced by a.
module symbol_replace
  import m_gen_pkg::*;
#(
  parameter  int unsigned J  = 14,
  parameter  int unsigned AW = 2,
  localparam int unsigned JW = jw_f(J)
) (
  input  logic [J*AW-1:0] vec,
  input  logic [JW-1:0]   j,
  input  logic [AW-1:0]   a,
  output logic [J*AW-1:0] rep_c
);

  always_comb begin
    rep_c = vec;
    for (int i = 0; i < J; i++) begin
      if (j == JW'(i)) rep_c[i*AW +: AW] = a;
    end
  end

endmodule

// File: rtl/m_gen_seq.sv
// M-generation sequencer: streams every single-symbol substitution of a
// latched vector over valid/ready, with loop order, self-skip and abort.
module m_gen_seq
  import m_gen_pkg::*;
#(
  parameter  int unsigned J         = 14,
  parameter  int unsigned A         = 2,
  parameter  bit          SKIP_SELF = 1'b1,
  localparam int unsigned AW        = aw_f(A),
  localparam int unsigned JW        = jw_f(J),
  localparam int unsigned CW        = cw_f(J, A)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [J*AW-1:0]   x_initial,
  input  logic              x_initial_tvalid,
  output logic              x_initial_tready,
  input  logic              mode,
  input  logic              abort,
  output logic [J*AW-1:0]   cand_tdata,
  output logic [JW+AW-1:0]  cand_tuser,
  output logic              cand_tvalid,
  input  logic              cand_tready,
  output logic              cand_tlast,
  output logic [CW-1:0]     beat_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW = J * AW;
  localparam int unsigned UW = JW + AW;

  state_e          state_q, state_d;
  logic [DW-1:0]   x_q, x_d;
  logic            mode_q, mode_d;
  logic [JW-1:0]   j_q, j_d;
  logic [AW-1:0]   a_q, a_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   expected_q, expected_d;
  logic            done_q, done_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic [UW-1:0]   tuser_q, tuser_d;
  logic            tready_q, tready_d;
  logic            busy_q, busy_d;

  logic [CW-1:0]   self_cnt_c;
  logic [AW-1:0]   sym_n_c;
  logic [DW-1:0]   rep_c;
  logic            self_c, fire_c, last_pair_c;

  // Positions whose initial symbol is in-alphabet each contribute one self pair.
  always_comb begin
    self_cnt_c = '0;
    for (int i = 0; i < J; i++) begin
      if (x_initial[i*AW +: AW] < AW'(A)) self_cnt_c = self_cnt_c + CW'(1);
    end
  end

  // In RUN, a non-valid cycle is exactly a self pair.
  assign self_c      = (state_q == ST_RUN) && !tvalid_q;
  assign fire_c      = tvalid_q && cand_tready;
  assign last_pair_c = (j_q == JW'(J - 1)) && (a_q == AW'(A - 1));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    mode_d     = mode_q;
    j_d        = j_q;
    a_d        = a_q;
    beat_d     = beat_q;
    expected_d = expected_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && x_initial_tvalid) begin
          x_d        = x_initial;
          mode_d     = mode;
          j_d        = '0;
          a_d        = '0;
          beat_d     = '0;
          expected_d = CW'(J * A) - (SKIP_SELF ? self_cnt_c : CW'(0));
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fire_c && tlast_q) begin
          beat_d  = beat_q + CW'(1);
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (self_c && last_pair_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (fire_c || self_c) begin
          if (fire_c) beat_d = beat_q + CW'(1);
          case (mode_q)
            MODE_J_OUTER: begin
              if (a_q == AW'(A - 1)) begin
                a_d = '0;
                j_d = j_q + JW'(1);
              end else begin
                a_d = a_q + AW'(1);
              end
            end
            MODE_A_OUTER: begin
              if (j_q == JW'(J - 1)) begin
                j_d = '0;
                a_d = a_q + AW'(1);
              end else begin
                j_d = j_q + JW'(1);
              end
            end
          endcase
        end
      end
    endcase
  end

  symbol_replace #(.J(J), .AW(AW)) u_replace (
    .vec   (x_d),
    .j     (j_d),
    .a     (a_d),
    .rep_c (rep_c)
  );

  // Stream outputs are registered from next state; payload holds while not valid.
  always_comb begin
    sym_n_c = '0;
    for (int i = 0; i < J; i++) begin
      if (j_d == JW'(i)) sym_n_c = x_d[i*AW +: AW];
    end
    tvalid_d = (state_d == ST_RUN) && !(SKIP_SELF && (a_d == sym_n_c));
    tdata_d  = tvalid_d ? rep_c : tdata_q;
    tuser_d  = tvalid_d ? {j_d, a_d} : tuser_q;
    tlast_d  = tvalid_d && (beat_d == expected_d - CW'(1));
    busy_d   = (state_d == ST_RUN);
    tready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      mode_q     <= 1'b0;
      j_q        <= '0;
      a_q        <= '0;
      beat_q     <= '0;
      expected_q <= '0;
      done_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tready_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      mode_q     <= mode_d;
      j_q        <= j_d;
      a_q        <= a_d;
      beat_q     <= beat_d;
      expected_q <= expected_d;
      done_q     <= done_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tready_q   <= tready_d;
      busy_q     <= busy_d;
    end
  end

  assign x_initial_tready = tready_q;
  assign cand_tdata       = tdata_q;
  assign cand_tuser       = tuser_q;
  assign cand_tvalid      = tvalid_q;
  assign cand_tlast       = tlast_q;
  assign beat_count       = beat_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
